// File: rtl/playback_sequencer.sv
// Streams sample words from memory through a prefetch FIFO to a registered audio output.
// Latency: SAMPLE/SAMPLE_VALID/UNDERRUN update one cycle after SAMPLE_TICK; a new MEM_REQ may follow an ACK with no gap.
// Backpressure: one request outstanding, held stable until MEM_ACK; fetching pauses while the FIFO is full.
module playback_sequencer #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PLAY,
    input  logic              PAUSE,
    input  logic              LOOP,
    input  logic [ADDR_W-1:0] END_ADDR,
    input  logic              SAMPLE_TICK,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] SAMPLE,
    output logic              SAMPLE_VALID,
    output logic              UNDERRUN,
    output logic              DONE
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_PAUSED,
        S_DRAIN,
        S_FINISHED,
        S_ABORT
    } state_t;

    state_t             state, state_n;
    logic               mem_req, req_n;
    logic [ADDR_W-1:0]  mem_addr, addr_n;
    logic               end_reached, end_n;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_n;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid, underrun;
    logic               ack, push, pop, underrun_n, tick_ok;

    assign MEM_REQ      = mem_req;
    assign MEM_ADDR     = mem_addr;
    assign SAMPLE       = sample;
    assign SAMPLE_VALID = sample_valid;
    assign UNDERRUN     = underrun;
    assign DONE         = (state == S_FINISHED);

    // Next-state, FIFO push/pop decisions, address advance and request issue.
    always_comb begin
        state_n    = state;
        push       = 1'b0;
        pop        = 1'b0;
        underrun_n = 1'b0;
        addr_n     = mem_addr;
        end_n      = end_reached;
        count_n    = count;
        req_n      = 1'b0;
        ack        = mem_req && MEM_ACK;
        tick_ok    = SAMPLE_TICK && !PAUSE;

        case (state)
            S_IDLE: begin
                if (PLAY) state_n = S_FILL;
            end
            S_FILL: begin
                // Ticks are ignored until the buffer is primed.
                if (count == DEPTH_C || end_reached) state_n = S_RUN;
            end
            S_RUN: begin
                if (tick_ok) begin
                    if (count != '0) pop = 1'b1;
                    else             underrun_n = 1'b1;
                end
                if (PAUSE)            state_n = S_PAUSED;
                else if (end_reached) state_n = S_DRAIN;
            end
            S_PAUSED: begin
                if (!PAUSE) state_n = S_RUN;
            end
            S_DRAIN: begin
                // An empty buffer here is the natural end of data, not an underrun.
                if (tick_ok && count != '0) pop = 1'b1;
                if (count == '0 && !mem_req) state_n = S_FINISHED;
            end
            S_FINISHED: begin
                state_n = S_FINISHED;
            end
            S_ABORT: begin
                if (MEM_ACK) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Stopping: wait out an in-flight request, otherwise go straight home.
        if (state != S_IDLE && state != S_ABORT && !PLAY) begin
            state_n    = (mem_req && !MEM_ACK) ? S_ABORT : S_IDLE;
            pop        = 1'b0;
            underrun_n = 1'b0;
        end

        // Data returned while aborting is dropped.
        push = ack && (state != S_ABORT);

        // A lowered END_ADDR below the current address also counts as the end.
        if (ack) begin
            if (mem_addr >= END_ADDR) begin
                if (LOOP) addr_n = '0;
                else      end_n  = 1'b1;
            end else begin
                addr_n = mem_addr + ADDR_W'(1);
            end
        end

        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase

        if (state_n == S_IDLE) begin
            count_n = '0;
            addr_n  = '0;
            end_n   = 1'b0;
        end

        if (mem_req && !MEM_ACK) begin
            req_n = 1'b1;
        end else begin
            req_n = (state_n == S_FILL || state_n == S_RUN || state_n == S_PAUSED)
                    && !end_n && (count_n < DEPTH_C);
        end
    end

    // Control state, request/address, FIFO pointers and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            end_reached  <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            mem_req      <= req_n;
            mem_addr     <= addr_n;
            end_reached  <= end_n;
            count        <= count_n;
            sample_valid <= pop;
            underrun     <= underrun_n;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                sample <= fifo_mem[rd_ptr];
            end
            if (underrun_n) sample <= '0;
            if (state_n == S_FINISHED) sample <= '0;
            if (state_n == S_IDLE) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                sample <= '0;
            end
        end
    end

    // FIFO storage; occupancy is tracked separately so contents need no reset.
    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= MEM_RDATA;
    end

endmodule
